varint_field_feeder: RTL and testbench
======================================

Name: varint_field_feeder

Overview:
- Upstream stage of the varint serializer: on `start`, fetches one scalar field value from source memory, normalizes it by protobuf field type, and drives the serializer's en/value/field_type/dst_addr inputs.
- Holds the serializer enabled until its `done`, captures its byte count, and reports the next (decremented) destination cursor.
- Sits between the message walker and the varint serializer.

Parameters:
- ADDR_W, 64, width of source/destination addresses.
- RD_TIMEOUT, 32, cycles to wait for rd_valid before declaring error.
- SER_TIMEOUT, 255, cycles to wait for vi_done before declaring error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  ADDR_W  address of the 64-bit source word.
- field_type  input  5  protobuf field type code.
- dst_addr  input  ADDR_W  destination cursor; serializer writes downward from here.
- rd_en  output  1  one-cycle memory read request.
- rd_addr  output  ADDR_W  read address.
- rd_data  input  64  read return data.
- rd_valid  input  1  rd_data valid strobe.
- vi_en  output  1  serializer enable.
- vi_value  output  64  normalized value.
- vi_field_type  output  5  type passed to serializer.
- vi_dst_addr  output  ADDR_W  destination passed to serializer.
- vi_done  input  1  serializer completion pulse.
- vi_bytes_written  input  4  serializer byte count, valid with vi_done.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = invalid type or timeout.
- bytes_written  output  4  bytes emitted by the last operation; held until next start.
- next_dst_addr  output  ADDR_W  dst_addr minus bytes_written; held until next start.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs and registers go to 0: rd_en, rd_addr, vi_en, vi_value, vi_field_type, vi_dst_addr, busy, done, err, bytes_written, next_dst_addr, timer.
  - Reset during READ_WAIT or SER abandons the operation. A late rd_valid or vi_done after reset is ignored.
- States: IDLE, READ, READ_WAIT, SER, FINISH.
- IDLE:
  - On start=1, latch src_addr, field_type and dst_addr into internal registers.
  - If the latched type is not varint-eligible, go to FINISH with err=1. Eligible types: 3 int64, 4 uint64, 5 int32, 8 bool, 13 uint32, 14 enum, 17 sint32, 18 sint64.
  - Otherwise go to READ.
  - start in any other state is ignored.
- READ (1 cycle):
  - rd_en=1 and rd_addr=latched src_addr.
  - Clear the timer; go to READ_WAIT.
- READ_WAIT:
  - On rd_valid, normalize rd_data into vi_value:
    - type 8: {63'b0, rd_data[0]}.
    - types 13 and 17: zero-extend rd_data[31:0].
    - types 5 and 14: sign-extend rd_data[31:0], so negatives produce 10 bytes.
    - types 3, 4 and 18: rd_data unmodified.
  - Then set vi_field_type=latched type, vi_dst_addr=latched dst, and go to SER.
  - If the timer reaches RD_TIMEOUT with no rd_valid, go to FINISH with err=1.
  - rd_valid outside READ_WAIT is ignored.
- SER:
  - vi_en=1 continuously; vi_value, vi_field_type and vi_dst_addr are stable for the whole state. The serializer clears its count when en drops, so en must not glitch.
  - On vi_done:
    - bytes_written <= vi_bytes_written.
    - next_dst_addr <= latched dst - vi_bytes_written, with zero-extended subtraction modulo 2^ADDR_W (wraps below 0).
    - Go to FINISH with err=0.
  - Timer at SER_TIMEOUT: go to FINISH with err=1, bytes_written=0, next_dst_addr=latched dst.
- FINISH (1 cycle):
  - vi_en=0, done=1, busy=1; err valid this cycle.
  - Next state is IDLE.
  - vi_en is therefore low for at least 2 cycles (FINISH plus IDLE) between operations.
- Simultaneous events:
  - vi_done on the same cycle as the timeout: vi_done wins.
  - rd_valid on the same cycle as the timeout: rd_valid wins.
- Latency: start to rd_en is 1 cycle. vi_done to done is 1 cycle.

Test Plan:
- uint64 (type 4), rd_data=300, dst=0x1000; responder returns vi_done with 2 -> vi_value=300 held under vi_en; done=1, err=0, bytes_written=2, next_dst_addr=0x0FFE.
- int32 (type 5), rd_data=0x00000000_FFFFFFFF; responder returns 10 -> vi_value=0xFFFFFFFF_FFFFFFFF; next_dst_addr=dst-10.
- bool (type 8), rd_data=0xFF -> vi_value=1. sint32 (type 17), rd_data=0xAAAA_AAAA_8000_0001 -> vi_value=0x0000_0000_8000_0001.
- field_type=1 (double) -> no rd_en, done on cycle 2 with err=1, bytes_written=0. Never return rd_valid (type 4) -> done with err=1 exactly RD_TIMEOUT cycles after READ_WAIT entry.
- Assert reset mid-SER -> vi_en, busy, done=0 immediately (async); a later vi_done is ignored; the next start completes normally.
- start pulsed while busy -> ignored. Back-to-back starts -> vi_en low ≥2 cycles between operations, and each next_dst_addr is correct.

Source files
------------

// File: rtl/varint_field_feeder.sv
// varint_field_feeder
//
// Upstream stage of the varint serializer. On a start request it fetches one
// 64-bit scalar field from source memory, normalizes it according to its
// protobuf field type, and holds the serializer enabled with a stable
// value/type/destination until the serializer reports completion. It then
// reports the byte count and the decremented destination cursor.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request pulse, only honoured while idle
//   src_addr            address of the 64-bit source word
//   field_type          protobuf field type code
//   dst_addr            destination cursor (serializer writes downward)
//   rd_en/rd_addr       one-cycle memory read request
//   rd_data/rd_valid    memory read return
//   vi_en               serializer enable, held high for the whole operation
//   vi_value            normalized value for the serializer
//   vi_field_type       field type passed to the serializer
//   vi_dst_addr         destination passed to the serializer
//   vi_done             serializer completion pulse
//   vi_bytes_written    serializer byte count, valid with vi_done
//   busy                high whenever not idle
//   done/err            one-cycle completion pulse and its error flag
//   bytes_written       bytes emitted by the last operation
//   next_dst_addr       dst_addr minus bytes_written
module varint_field_feeder #(
  parameter int ADDR_W      = 64,
  parameter int RD_TIMEOUT  = 32,
  parameter int SER_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [4:0]        field_type,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  input  logic              rd_valid,
  output logic              vi_en,
  output logic [63:0]       vi_value,
  output logic [4:0]        vi_field_type,
  output logic [ADDR_W-1:0] vi_dst_addr,
  input  logic              vi_done,
  input  logic [3:0]        vi_bytes_written,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        bytes_written,
  output logic [ADDR_W-1:0] next_dst_addr
);

  // One shared timer serves both wait states, so it is sized for the longer one.
  localparam int TMAX    = (RD_TIMEOUT > SER_TIMEOUT) ? RD_TIMEOUT : SER_TIMEOUT;
  localparam int TIMER_W = $clog2(TMAX + 1);
  // The timer is 0 in the first cycle of a wait state, so the last allowed
  // cycle is TIMEOUT-1; a response arriving in that cycle still wins.
  localparam logic [TIMER_W-1:0] RD_LAST  = TIMER_W'(RD_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SER_LAST = TIMER_W'(SER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_READ_WAIT,
    S_SER,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          type_q, type_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                vi_en_q, vi_en_d;
  logic [63:0]         vi_value_q, vi_value_d;
  logic [4:0]          vi_type_q, vi_type_d;
  logic [ADDR_W-1:0]   vi_dst_q, vi_dst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [3:0]          bytes_q, bytes_d;
  logic [ADDR_W-1:0]   next_dst_q, next_dst_d;

  // Field types the varint wire format can carry.
  function automatic logic is_varint_type(input logic [4:0] t);
    case (t)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: is_varint_type = 1'b1;
      default:                                            is_varint_type = 1'b0;
    endcase
  endfunction

  // int32 and enum are sign-extended so negative values encode as 10 bytes;
  // uint32 and sint32 (already zigzagged upstream) are zero-extended.
  function automatic logic [63:0] normalize(input logic [4:0] t, input logic [63:0] d);
    case (t)
      5'd8:           normalize = {63'b0, d[0]};
      5'd13, 5'd17:   normalize = {32'b0, d[31:0]};
      5'd5, 5'd14:    normalize = {{32{d[31]}}, d[31:0]};
      default:        normalize = d;
    endcase
  endfunction

  // Next-state and datapath logic. Registered outputs are derived from the
  // next state so that vi_en, rd_en, busy and done come straight off flops.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    dst_d      = dst_q;
    timer_d    = timer_q;
    rd_addr_d  = rd_addr_q;
    vi_value_d = vi_value_q;
    vi_type_d  = vi_type_q;
    vi_dst_d   = vi_dst_q;
    err_d      = err_q;
    bytes_d    = bytes_q;
    next_dst_d = next_dst_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          type_d     = field_type;
          dst_d      = dst_addr;
          rd_addr_d  = src_addr;
          err_d      = 1'b0;
          bytes_d    = 4'd0;
          next_dst_d = dst_addr;
          if (is_varint_type(field_type)) begin
            state_d = S_READ;
          end else begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end
        end
      end

      S_READ: begin
        timer_d = '0;
        state_d = S_READ_WAIT;
      end

      S_READ_WAIT: begin
        if (rd_valid) begin
          vi_value_d = normalize(type_q, rd_data);
          vi_type_d  = type_q;
          vi_dst_d   = dst_q;
          timer_d    = '0;
          state_d    = S_SER;
        end else if (timer_q == RD_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SER: begin
        if (vi_done) begin
          bytes_d    = vi_bytes_written;
          next_dst_d = dst_q - {{(ADDR_W-4){1'b0}}, vi_bytes_written};
          err_d      = 1'b0;
          state_d    = S_FINISH;
        end else if (timer_q == SER_LAST) begin
          bytes_d    = 4'd0;
          next_dst_d = dst_q;
          err_d      = 1'b1;
          state_d    = S_FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_en_d = (state_d == S_READ);
    vi_en_d = (state_d == S_SER);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      dst_q      <= '0;
      timer_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      vi_en_q    <= 1'b0;
      vi_value_q <= '0;
      vi_type_q  <= '0;
      vi_dst_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bytes_q    <= '0;
      next_dst_q <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      dst_q      <= dst_d;
      timer_q    <= timer_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      vi_en_q    <= vi_en_d;
      vi_value_q <= vi_value_d;
      vi_type_q  <= vi_type_d;
      vi_dst_q   <= vi_dst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bytes_q    <= bytes_d;
      next_dst_q <= next_dst_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign vi_en         = vi_en_q;
  assign vi_value      = vi_value_q;
  assign vi_field_type = vi_type_q;
  assign vi_dst_addr   = vi_dst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bytes_written = bytes_q;
  assign next_dst_addr = next_dst_q;

endmodule

// File: tb/tb_varint_field_feeder.sv
// Testbench for varint_field_feeder: directed cases from the field-type rules
// plus randomized operations, all checked against a behavioural model.
module tb_varint_field_feeder;

  localparam int ADDR_W      = 64;
  localparam int RD_TIMEOUT  = 32;
  localparam int SER_TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [4:0]        field_type = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data = '0;
  logic              rd_valid = 1'b0;
  logic              vi_en;
  logic [63:0]       vi_value;
  logic [4:0]        vi_field_type;
  logic [ADDR_W-1:0] vi_dst_addr;
  logic              vi_done = 1'b0;
  logic [3:0]        vi_bytes_written = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic [3:0]        bytes_written;
  logic [ADDR_W-1:0] next_dst_addr;

  int total = 0;
  int bad   = 0;

  // Model expectations for the operation in flight.
  logic [63:0] exp_value = '0;
  logic [4:0]  exp_ft    = '0;
  logic [63:0] exp_dst   = '0;
  logic        exp_err   = 1'b0;
  logic [3:0]  exp_bytes = '0;
  logic [63:0] exp_next  = '0;

  varint_field_feeder #(
    .ADDR_W(ADDR_W),
    .RD_TIMEOUT(RD_TIMEOUT),
    .SER_TIMEOUT(SER_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .field_type(field_type),
    .dst_addr(dst_addr),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .vi_en(vi_en),
    .vi_value(vi_value),
    .vi_field_type(vi_field_type),
    .vi_dst_addr(vi_dst_addr),
    .vi_done(vi_done),
    .vi_bytes_written(vi_bytes_written),
    .busy(busy),
    .done(done),
    .err(err),
    .bytes_written(bytes_written),
    .next_dst_addr(next_dst_addr)
  );

  always #5 clk = ~clk;

  // Comparison bookkeeping shared by the driver and the compare process.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Model: set membership of varint-capable types.
  function automatic bit model_eligible(input logic [4:0] t);
    int ok[8] = '{3, 4, 5, 8, 13, 14, 17, 18};
    bit r = 1'b0;
    foreach (ok[i]) if (int'(t) == ok[i]) r = 1'b1;
    return r;
  endfunction

  // Model: value normalization expressed arithmetically.
  function automatic logic [63:0] model_norm(input logic [4:0] t, input logic [63:0] d);
    longint s;
    int lo;
    if (t == 5'd8) return d & 64'd1;
    if (t == 5'd13 || t == 5'd17) return d % (64'd1 << 32);
    if (t == 5'd5 || t == 5'd14) begin
      lo = int'(d[31:0]);
      s  = longint'(lo);
      return 64'(s);
    end
    return d;
  endfunction

  // Model: number of 7-bit groups a varint needs.
  function automatic int varint_len(input logic [63:0] v);
    int n = 1;
    logic [63:0] x = v;
    while (x >= 64'd128) begin
      x = x >> 7;
      n++;
    end
    return n;
  endfunction

  task tick();
    @(posedge clk);
    #1;
  endtask

  // Disturb inputs that must be ignored while an operation is in flight.
  task automatic poke();
    start      = 1'($urandom_range(0, 1));
    src_addr   = {$urandom, $urandom};
    field_type = 5'($urandom_range(0, 31));
    dst_addr   = {$urandom, $urandom};
  endtask

  // Compare process: serializer inputs must match the model for every SER
  // cycle, done results on every done cycle, and vi_en must stay low at
  // least two cycles between operations.
  int  low_run = 0;
  bit  seen_en = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      low_run = 0;
      seen_en = 1'b0;
    end else begin
      if (vi_en) begin
        if (seen_en && low_run > 0)
          checkOutput("vi_en_gap_ge2", 64'(low_run >= 2), 64'd1);
        checkOutput("vi_value", vi_value, exp_value);
        checkOutput("vi_field_type", 64'(vi_field_type), 64'(exp_ft));
        checkOutput("vi_dst_addr", vi_dst_addr, exp_dst);
        low_run = 0;
        seen_en = 1'b1;
      end else begin
        low_run++;
      end
      if (done) begin
        checkOutput("done_err", 64'(err), 64'(exp_err));
        checkOutput("done_bytes", 64'(bytes_written), 64'(exp_bytes));
        checkOutput("done_next_dst", next_dst_addr, exp_next);
        checkOutput("done_busy", 64'(busy), 64'd1);
      end
    end
  end

  // Run one operation, acting as both memory and serializer responder.
  task automatic applyStimulus(input logic [4:0] ft, input logic [63:0] data, input logic [63:0] dst,
                               input int rd_dly, input int ser_dly, input bit drop_rd,
                               input bit drop_ser, input bit disturb);
    logic [63:0] src;
    bit elig;
    int len;
    int n;
    src  = {$urandom, $urandom};
    elig = model_eligible(ft);
    exp_value = model_norm(ft, data);
    exp_ft    = ft;
    exp_dst   = dst;
    len       = varint_len(exp_value);
    if (!elig || drop_rd || drop_ser) begin
      exp_err   = 1'b1;
      exp_bytes = 4'd0;
      exp_next  = dst;
    end else begin
      exp_err   = 1'b0;
      exp_bytes = 4'(len);
      exp_next  = dst - 64'(len);
    end

    start = 1'b1; src_addr = src; field_type = ft; dst_addr = dst;
    tick();
    start = 1'b0; src_addr = {$urandom, $urandom}; field_type = 5'($urandom_range(0, 31));
    dst_addr = {$urandom, $urandom};
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("rd_en_latency", 64'(rd_en), 64'(elig));
    if (!elig) begin
      checkOutput("done_invalid_type", 64'(done), 64'd1);
      tick();
      checkOutput("idle_after_invalid", 64'(busy), 64'd0);
      return;
    end
    checkOutput("rd_addr", rd_addr, src);
    tick();
    checkOutput("rd_en_one_cycle", 64'(rd_en), 64'd0);

    if (drop_rd) begin
      n = 0;
      while (!done && n < RD_TIMEOUT + 10) begin
        if (disturb) poke();
        tick();
        n++;
      end
      start = 1'b0;
      checkOutput("rd_timeout_cycles", 64'(n), 64'(RD_TIMEOUT));
      tick();
      checkOutput("idle_after_rd_timeout", 64'(busy), 64'd0);
      return;
    end

    repeat (rd_dly) begin
      if (disturb) poke();
      tick();
    end
    start = 1'b0;
    rd_valid = 1'b1; rd_data = data;
    tick();
    rd_valid = 1'b0; rd_data = {$urandom, $urandom};
    checkOutput("vi_en_on_ser", 64'(vi_en), 64'd1);

    if (drop_ser) begin
      n = 0;
      while (!done && n < SER_TIMEOUT + 10) begin
        if (disturb) poke();
        tick();
        n++;
      end
      start = 1'b0;
      checkOutput("ser_timeout_cycles", 64'(n), 64'(SER_TIMEOUT));
      tick();
      checkOutput("idle_after_ser_timeout", 64'(busy), 64'd0);
      return;
    end

    repeat (ser_dly) begin
      if (disturb) begin
        poke();
        rd_valid = 1'($urandom_range(0, 1));
        rd_data  = {$urandom, $urandom};
      end
      tick();
    end
    start = 1'b0; rd_valid = 1'b0;
    vi_done = 1'b1; vi_bytes_written = 4'(len);
    tick();
    vi_done = 1'b0; vi_bytes_written = 4'($urandom_range(0, 15));
    checkOutput("done_latency", 64'(done), 64'd1);
    checkOutput("vi_en_low_finish", 64'(vi_en), 64'd0);
    tick();
    checkOutput("idle_done_low", 64'(done), 64'd0);
    checkOutput("idle_busy_low", 64'(busy), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] dst;
    logic [4:0]  ft;

    // Pin the model itself with hand-computed values.
    checkOutput("model_len_300", 64'(varint_len(64'd300)), 64'd2);
    checkOutput("model_int32_neg", model_norm(5'd5, 64'h0000_0000_FFFF_FFFF), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("model_len_neg", 64'(varint_len(64'hFFFF_FFFF_FFFF_FFFF)), 64'd10);
    checkOutput("model_bool", model_norm(5'd8, 64'hFF), 64'd1);
    checkOutput("model_sint32", model_norm(5'd17, 64'hAAAA_AAAA_8000_0001), 64'h0000_0000_8000_0001);
    checkOutput("model_double_ineligible", 64'(model_eligible(5'd1)), 64'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_vi_en", 64'(vi_en), 64'd0);
    checkOutput("reset_rd_en", 64'(rd_en), 64'd0);
    checkOutput("reset_next_dst", next_dst_addr, 64'd0);
    checkOutput("reset_vi_value", vi_value, 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] directed cases");
    applyStimulus(5'd4, 64'd300, 64'h1000, 2, 3, 1'b0, 1'b0, 1'b0);
    checkOutput("uint64_bytes_lit", 64'(bytes_written), 64'd2);
    checkOutput("uint64_next_lit", next_dst_addr, 64'h0FFE);
    applyStimulus(5'd5, 64'h0000_0000_FFFF_FFFF, 64'h2000, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("int32_next_lit", next_dst_addr, 64'h1FF6);
    applyStimulus(5'd8, 64'hFF, 64'h300, 1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd17, 64'hAAAA_AAAA_8000_0001, 64'h400, 4, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd1, 64'h1234, 64'h500, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("double_err_lit", 64'(err), 64'd1);
    checkOutput("double_bytes_lit", 64'(bytes_written), 64'd0);
    applyStimulus(5'd4, 64'h55, 64'h600, 0, 0, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd18, 64'h77, 64'h700, 0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd3, 64'h8000_0000_0000_0000, 64'h800, RD_TIMEOUT - 1, SER_TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd14, 64'h0000_0000_8000_0000, 64'd3, 1, 1, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_next_lit", next_dst_addr, 64'hFFFF_FFFF_FFFF_FFF9);

    $display("[TB] reset during SER");
    exp_value = 64'd99; exp_ft = 5'd4; exp_dst = 64'h900;
    start = 1'b1; src_addr = 64'h40; field_type = 5'd4; dst_addr = 64'h900;
    tick();
    start = 1'b0;
    tick();
    rd_valid = 1'b1; rd_data = 64'd99;
    tick();
    rd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("async_reset_vi_en", 64'(vi_en), 64'd0);
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    checkOutput("async_reset_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    vi_done = 1'b1; vi_bytes_written = 4'd1; rd_valid = 1'b1;
    tick();
    vi_done = 1'b0; rd_valid = 1'b0;
    checkOutput("late_vi_done_done", 64'(done), 64'd0);
    checkOutput("late_vi_done_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("late_vi_done_bytes", 64'(bytes_written), 64'd0);
    applyStimulus(5'd4, 64'd1, 64'h900, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized cases");
    for (int i = 0; i < 40; i++) begin
      ft = 5'($urandom_range(0, 19));
      case ($urandom_range(0, 3))
        0: d = {$urandom, $urandom};
        1: d = {$urandom, 1'b1, 31'($urandom)};
        2: d = 64'($urandom_range(0, 300));
        default: d = {32'($urandom), 32'hFFFF_FFFF};
      endcase
      dst = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      applyStimulus(ft, d, dst, $urandom_range(0, RD_TIMEOUT - 1), $urandom_range(0, 20),
                    1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
